// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Next index in round-robin order, wrapping at n-1 rather than at a power of two.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the N upstream valid/ready lanes and the single merged downstream stream.
interface stream_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int L  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
);

    logic [N-1:0]   valid_f;
    logic [N*L-1:0] data_f;
    logic [N-1:0]   last_f;
    logic [N-1:0]   ready_f;

    logic           valid_b;
    logic [L-1:0]   data_b;
    logic           last_b;
    logic [IW-1:0]  id_b;
    logic           ready_b;

    // Requesters plus downstream consumer.
    modport master (
        output valid_f, data_f, last_f, ready_b,
        input  ready_f, valid_b, data_b, last_b, id_b
    );

    // The arbiter itself.
    modport slave (
        input  valid_f, data_f, last_f, ready_b,
        output ready_f, valid_b, data_b, last_b, id_b
    );

endinterface

// File: rtl/stream_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // Rotate a doubled request vector so ptr lands at bit 0, find the lowest set bit, then un-rotate.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        gnt_idx = sum[IW-1:0];
        any     = |req;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of N valid/ready producers into one registered, id-tagged output stream.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int L   = 8,
    parameter int N   = 4,
    parameter int PKT = 0
) (
    input  logic                clk,
    input  logic                rst,
    stream_rr_arbiter_if.slave  bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          valid_b_q, valid_b_d;
    logic [L-1:0]  data_b_q, data_b_d;
    logic          last_b_q, last_b_d;
    logic [IW-1:0] id_b_q, id_b_d;

    logic          load;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] g_idx;
    logic [L-1:0]  g_data;
    logic          g_last;
    logic          g_valid;
    logic          g_ok;
    logic          xfer;
    logic [N-1:0]  ready_f;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (bus.valid_f),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Choose the candidate lane (owner while locked, round-robin pick otherwise) and decode ready_f.
    always_comb begin
        load    = !valid_b_q || bus.ready_b;
        g_idx   = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
        g_ok    = (state_q == ARB_LOCKED) || pick_any;
        g_data  = '0;
        g_last  = 1'b0;
        g_valid = 1'b0;
        ready_f = '0;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == g_idx) begin
                g_data     = bus.data_f[i*L +: L];
                g_last     = bus.last_f[i];
                g_valid    = bus.valid_f[i];
                ready_f[i] = load && g_ok;
            end
        end
        xfer = g_valid && load && g_ok;
    end

    // Next-state logic for the output register, pointer and packet lock.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        valid_b_d = valid_b_q;
        data_b_d  = data_b_q;
        last_b_d  = last_b_q;
        id_b_d    = id_b_q;
        if (xfer) begin
            valid_b_d = 1'b1;
            data_b_d  = g_data;
            last_b_d  = g_last | (PKT == 0);
            id_b_d    = g_idx;
            if (PKT == 0) begin
                ptr_d = IW'(wrap_inc(int'(g_idx), N));
            end else if (g_last) begin
                state_d = ARB_IDLE;
                ptr_d   = IW'(wrap_inc(int'(g_idx), N));
            end else if (state_q == ARB_IDLE) begin
                state_d = ARB_LOCKED;
                owner_d = g_idx;
            end
        end else if (bus.ready_b) begin
            valid_b_d = 1'b0;
        end
    end

    // All arbiter state and the output stage, with synchronous reset discarding any pending beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            valid_b_q <= 1'b0;
            data_b_q  <= '0;
            last_b_q  <= 1'b0;
            id_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            valid_b_q <= valid_b_d;
            data_b_q  <= data_b_d;
            last_b_q  <= last_b_d;
            id_b_q    <= id_b_d;
        end
    end

    assign bus.ready_f = ready_f;
    assign bus.valid_b = valid_b_q;
    assign bus.data_b  = data_b_q;
    assign bus.last_b  = last_b_q;
    assign bus.id_b    = id_b_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Testbench for stream_rr_arbiter: three builds (N=4 beat mode, N=4 packet mode, N=3 beat mode)
// checked each cycle against a behavioural model of the arbitration rules.
module tb_stream_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.N(4), .L(8)) a_if ();
    stream_rr_arbiter_if #(.N(4), .L(8)) b_if ();
    stream_rr_arbiter_if #(.N(3), .L(8)) c_if ();

    stream_rr_arbiter #(.L(8), .N(4), .PKT(0)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    stream_rr_arbiter #(.L(8), .N(4), .PKT(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
    stream_rr_arbiter #(.L(8), .N(3), .PKT(0)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

    logic [3:0]  v   [3];
    logic [3:0]  l   [3];
    logic [31:0] d   [3];
    logic        rb  [3];
    logic [3:0]  erf [3];
    logic [3:0]  acc [3];
    logic [3:0]  obs_rf  [3];
    logic [13:0] obs_out [3];

    assign a_if.valid_f = v[0];
    assign a_if.data_f  = d[0];
    assign a_if.last_f  = l[0];
    assign a_if.ready_b = rb[0];
    assign b_if.valid_f = v[1];
    assign b_if.data_f  = d[1];
    assign b_if.last_f  = l[1];
    assign b_if.ready_b = rb[1];
    assign c_if.valid_f = v[2][2:0];
    assign c_if.data_f  = d[2][23:0];
    assign c_if.last_f  = l[2][2:0];
    assign c_if.ready_b = rb[2];

    assign obs_rf[0]  = a_if.ready_f;
    assign obs_rf[1]  = b_if.ready_f;
    assign obs_rf[2]  = {1'b0, c_if.ready_f};
    assign obs_out[0] = {a_if.valid_b, a_if.last_b, 2'b00, a_if.id_b, a_if.data_b};
    assign obs_out[1] = {b_if.valid_b, b_if.last_b, 2'b00, b_if.id_b, b_if.data_b};
    assign obs_out[2] = {c_if.valid_b, c_if.last_b, 2'b00, c_if.id_b, c_if.data_b};

    typedef struct {
        logic       ov;
        logic [7:0] od;
        logic       ol;
        int         oid;
        int         ptr;
        logic       locked;
        int         owner;
    } mstate_t;

    mstate_t ms [3];
    int      nn [3];
    logic    pk [3];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic mstate_t modelReset();
        mstate_t s;
        s.ov = 1'b0; s.od = 8'h00; s.ol = 1'b0; s.oid = 0;
        s.ptr = 0; s.locked = 1'b0; s.owner = 0;
        return s;
    endfunction

    // Which lane may hand over a beat this cycle, straight from the arbitration rules.
    function automatic logic [3:0] modelReady(input mstate_t s, input int n, input logic [3:0] vv, input logic r);
        if (s.ov && !r) return 4'b0000;
        if (s.locked) return 4'(1 << s.owner);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (s.ptr + k) % n;
            if (vv[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    function automatic mstate_t modelStep(input mstate_t s, input int n, input logic p,
                                          input logic [3:0] vv, input logic [31:0] dd,
                                          input logic [3:0] ll, input logic r);
        logic [3:0] rdy;
        int g;
        rdy = modelReady(s, n, vv, r);
        g = -1;
        for (int k = 0; k < n; k++) if (vv[k] && rdy[k]) g = k;
        if (g >= 0) begin
            s.ov  = 1'b1;
            s.od  = dd[g*8 +: 8];
            s.ol  = ll[g] | !p;
            s.oid = g;
            if (!p) begin
                s.ptr = (g + 1) % n;
            end else if (ll[g]) begin
                s.locked = 1'b0;
                s.ptr = (g + 1) % n;
            end else if (!s.locked) begin
                s.locked = 1'b1;
                s.owner = g;
            end
        end else if (r) begin
            s.ov = 1'b0;
        end
        return s;
    endfunction

    function automatic logic [13:0] expOut(input mstate_t s);
        return {s.ov, s.ol, 4'(s.oid), s.od};
    endfunction

    // One clock: check ready_f before the edge, advance the model, check the output register after it.
    task automatic runCycle();
        #1;
        for (int i = 0; i < 3; i++) begin
            erf[i] = modelReady(ms[i], nn[i], v[i], rb[i]);
            acc[i] = v[i] & erf[i];
            checkOutput($sformatf("ready_f[%0d]", i), 32'(obs_rf[i]), 32'(erf[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) ms[i] = modelReset();
            else     ms[i] = modelStep(ms[i], nn[i], pk[i], v[i], d[i], l[i], rb[i]);
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("out[%0d]", i), 32'(obs_out[i]), 32'(expOut(ms[i])));
        end
        @(negedge clk);
    endtask

    // Random requester traffic that keeps each unaccepted beat stable until it is taken.
    task automatic applyStimulus(input int i, input int dens);
        for (int k = 0; k < nn[i]; k++) begin
            if (v[i][k] && !acc[i][k]) continue;
            v[i][k] = ($urandom_range(0, 99) < dens);
            d[i][k*8 +: 8] = 8'($urandom);
            l[i][k] = ($urandom_range(0, 2) == 0);
        end
        rb[i] = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        nn[0] = 4; nn[1] = 4; nn[2] = 3;
        pk[0] = 1'b0; pk[1] = 1'b1; pk[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v[i] = '0; l[i] = '0; d[i] = '0; rb[i] = 1'b1; acc[i] = '0; erf[i] = '0;
            ms[i] = modelReset();
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_out", 32'(obs_out[i]), 32'h0);
            checkOutput("reset_ready", 32'(obs_rf[i]), 32'h0);
        end

        // All lanes valid: strict rotation, one beat per cycle.
        v[0] = 4'hF; d[0] = 32'h44332211;
        v[2] = 4'h7; d[2] = 32'h00CCBBAA;
        for (int j = 0; j < 10; j++) begin
            runCycle();
            checkOutput("seq_a_id", 32'(a_if.id_b), 32'(j % 4));
            checkOutput("seq_a_data", 32'(a_if.data_b), 32'(8'h11 * ((j % 4) + 1)));
            checkOutput("seq_c_id", 32'(c_if.id_b), 32'(j % 3));
        end
        v[2] = 4'h0;

        // Pointer sits at 2 with only lanes 0 and 1 requesting: wrap past 3.
        v[0] = 4'b0011;
        runCycle();
        checkOutput("wrap_first", 32'(a_if.id_b), 32'd0);
        runCycle();
        checkOutput("wrap_second", 32'(a_if.id_b), 32'd1);
        v[0] = 4'hF;
        runCycle();
        checkOutput("ptr_after_wrap", 32'(a_if.id_b), 32'd2);

        // Downstream stall with a full output register.
        v[0] = 4'b0001; rb[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            runCycle();
            checkOutput("stall_ready", 32'(obs_rf[0]), 32'h0);
            checkOutput("stall_id", 32'(a_if.id_b), 32'd2);
            checkOutput("stall_data", 32'(a_if.data_b), 32'h33);
        end
        rb[0] = 1'b1;
        runCycle();
        checkOutput("unstall_id", 32'(a_if.id_b), 32'd0);
        v[0] = 4'h0;

        // Packet mode: lane 1 holds the grant across a 3-beat packet while lane 0 waits.
        v[1] = 4'b0001; l[1] = 4'b0001; d[1] = 32'h000000A0;
        runCycle();
        for (int j = 0; j < 4; j++) begin
            v[1] = (j < 3) ? 4'b0011 : 4'b0001;
            l[1] = (j == 2) ? 4'b0011 : 4'b0001;
            d[1] = {16'h0000, 8'(8'hB1 + j), 8'hA1};
            runCycle();
            checkOutput("pkt_id", 32'(b_if.id_b), (j < 3) ? 32'd1 : 32'd0);
            checkOutput("pkt_last", 32'(b_if.last_b), (j < 2) ? 32'd0 : 32'd1);
        end

        // Reset in the middle of a packet from lane 3.
        v[1] = 4'b1000; l[1] = 4'b0000; d[1] = 32'hC1000000;
        runCycle();
        d[1] = 32'hC2000000;
        runCycle();
        checkOutput("mid_pkt_id", 32'(b_if.id_b), 32'd3);
        rst = 1'b1;
        runCycle();
        checkOutput("rst_mid_valid", 32'(b_if.valid_b), 32'd0);
        rst = 1'b0;
        v[1] = 4'b1010; l[1] = 4'b1010; d[1] = 32'hD300D100;
        runCycle();
        checkOutput("post_rst_id", 32'(b_if.id_b), 32'd1);
        v[1] = 4'h0; l[1] = 4'h0;
        runCycle();

        // Randomised traffic on all three builds, with the occasional reset.
        for (int j = 0; j < 800; j++) begin
            for (int i = 0; i < 3; i++) applyStimulus(i, 60);
            rst = ($urandom_range(0, 199) == 0);
            runCycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
